// File: rtl/led_pattern_gen.sv
// LED pattern generator: programmable prescaler tick driving one of four
// LED patterns (binary count, all-blink, bouncing dot, PWM breathing).
module led_pattern_gen #(
  parameter int N_LEDS   = 10,
  parameter int TICK_DIV = 5000000,
  parameter int PWM_W    = 8
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic [1:0]        MODE,
  input  logic [1:0]        SPEED,
  input  logic              PAUSE,
  output logic [N_LEDS-1:0] LEDR,
  output logic              TICK
);

  localparam int PRE_W = $clog2(TICK_DIV + 1);
  localparam int POS_W = $clog2(N_LEDS);

  localparam logic [PRE_W-1:0] DIV_V        = PRE_W'(TICK_DIV);
  localparam logic [POS_W-1:0] POS_TOP      = POS_W'(N_LEDS - 1);
  localparam logic [POS_W-1:0] POS_NEXT_TOP = POS_W'(N_LEDS - 2);
  localparam logic [PWM_W-1:0] DUTY_TOP     = '1;

  typedef enum logic [1:0] {
    MODE_COUNT   = 2'b00,
    MODE_BLINK   = 2'b01,
    MODE_BOUNCE  = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  mode_e             mode_q, mode_d, mode_in;
  dir_e              dir_q, dir_d;
  logic [PRE_W-1:0]  pre_q, pre_d, per_m1;
  logic              tick_q, tick_d;
  logic [N_LEDS-1:0] cnt_q, cnt_d;
  logic              phase_q, phase_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [PWM_W-1:0]  duty_q, duty_d;
  logic [PWM_W-1:0]  pwm_q, pwm_d;
  logic [N_LEDS-1:0] leds_q, leds_d;

  // Map the registered pattern state onto the LED bank.
  function automatic logic [N_LEDS-1:0] led_decode(
    input mode_e             mode,
    input logic [N_LEDS-1:0] cnt,
    input logic              phase,
    input logic [POS_W-1:0]  pos,
    input logic [PWM_W-1:0]  duty,
    input logic [PWM_W-1:0]  pwm
  );
    logic [N_LEDS-1:0] leds;
    case (mode)
      MODE_COUNT:  leds = cnt;
      MODE_BLINK:  leds = {N_LEDS{phase}};
      MODE_BOUNCE: leds = N_LEDS'(1) << pos;
      default:     leds = (pwm < duty) ? '1 : '0;
    endcase
    return leds;
  endfunction

  // Next-state: mode change beats pause, pause beats prescaler and tick.
  always_comb begin
    mode_in = mode_e'(MODE);
    per_m1  = (DIV_V >> SPEED) - PRE_W'(1);
    mode_d  = mode_in;
    dir_d   = dir_q;
    pre_d   = pre_q;
    tick_d  = 1'b0;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    pos_d   = pos_q;
    duty_d  = duty_q;
    pwm_d   = pwm_q + PWM_W'(1);
    leds_d  = led_decode(mode_q, cnt_q, phase_q, pos_q, duty_q, pwm_q);

    if (mode_in != mode_q) begin
      // Restart the new pattern from its origin with a full prescaler period.
      pre_d   = '0;
      cnt_d   = '0;
      phase_d = 1'b0;
      pos_d   = '0;
      duty_d  = '0;
      pwm_d   = '0;
      dir_d   = DIR_UP;
    end else if (!PAUSE) begin
      // ">=" rather than "==" so a speed-up past the current count fires at once.
      if (pre_q >= per_m1) begin
        pre_d  = '0;
        tick_d = 1'b1;
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end

      if (tick_q) begin
        case (mode_q)
          MODE_COUNT: cnt_d = cnt_q + N_LEDS'(1);
          MODE_BLINK: phase_d = ~phase_q;
          MODE_BOUNCE: begin
            if (dir_q == DIR_UP) begin
              if (pos_q == POS_TOP) begin
                dir_d = DIR_DOWN;
                pos_d = POS_NEXT_TOP;
              end else begin
                pos_d = pos_q + POS_W'(1);
              end
            end else begin
              if (pos_q == '0) begin
                dir_d = DIR_UP;
                pos_d = POS_W'(1);
              end else begin
                pos_d = pos_q - POS_W'(1);
              end
            end
          end
          default: begin
            if (dir_q == DIR_UP) begin
              if (duty_q == DUTY_TOP) begin
                dir_d  = DIR_DOWN;
                duty_d = duty_q - PWM_W'(1);
              end else begin
                duty_d = duty_q + PWM_W'(1);
              end
            end else begin
              if (duty_q == '0) begin
                dir_d  = DIR_UP;
                duty_d = PWM_W'(1);
              end else begin
                duty_d = duty_q - PWM_W'(1);
              end
            end
          end
        endcase
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      mode_q  <= mode_e'(MODE);
      dir_q   <= DIR_UP;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      pos_q   <= '0;
      duty_q  <= '0;
      pwm_q   <= '0;
      leds_q  <= '0;
    end else begin
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      pos_q   <= pos_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
      leds_q  <= leds_d;
    end
  end

  assign LEDR = leds_q;
  assign TICK = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with N_LEDS=4, TICK_DIV=8, PWM_W=3.
module tb_led_pattern_gen;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N  = 1'b0;
  logic [1:0] MODE     = 2'b00;
  logic [1:0] SPEED    = 2'b00;
  logic       PAUSE    = 1'b0;
  logic [3:0] LEDR;
  logic       TICK;

  int checks = 0;
  int errors = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  led_pattern_gen #(
    .N_LEDS  (4),
    .TICK_DIV(8),
    .PWM_W   (3)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RESET_N (RESET_N),
    .MODE    (MODE),
    .SPEED   (SPEED),
    .PAUSE   (PAUSE),
    .LEDR    (LEDR),
    .TICK    (TICK)
  );

  task automatic cyc();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One reset edge with the given MODE/SPEED, then release.
  task automatic do_reset(input logic [1:0] m, input logic [1:0] s);
    RESET_N = 1'b0;
    MODE    = m;
    SPEED   = s;
    PAUSE   = 1'b0;
    cyc();
    chk("rst_led", 32'(LEDR), 32'h0);
    chk("rst_tick", 32'(TICK), 32'h0);
    RESET_N = 1'b1;
  endtask

  // Pattern step index shown on LEDR after edge k following reset release.
  function automatic int step_idx(input int k);
    return (k < 2) ? 0 : (k - 2) / 8;
  endfunction

  function automatic logic [3:0] bounce_exp(input int n);
    case (n % 6)
      0: return 4'b0001;
      1: return 4'b0010;
      2: return 4'b0100;
      3: return 4'b1000;
      4: return 4'b0100;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic int tri_duty(input int n);
    int m;
    m = n % 14;
    return (m <= 7) ? m : 14 - m;
  endfunction

  initial begin
    cyc();

    // Count mode, 140 cycles: covers ticks every 8 cycles and the 15 -> 0 wrap.
    do_reset(2'b00, 2'b00);
    for (int k = 1; k <= 140; k++) begin
      cyc();
      chk("cnt_tick", 32'(TICK), 32'((k % 8) == 0));
      chk("cnt_led", 32'(LEDR), 32'(step_idx(k) % 16));
    end

    // Pause at LEDR=5 (prescaler at 2), hold 20 cycles, then resume.
    do_reset(2'b00, 2'b00);
    for (int k = 1; k <= 42; k++) cyc();
    chk("pause_pre_led", 32'(LEDR), 32'd5);
    PAUSE = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("pause_tick", 32'(TICK), 32'd0);
      chk("pause_led", 32'(LEDR), 32'd5);
    end
    PAUSE = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("resume_tick0", 32'(TICK), 32'd0);
    end
    cyc();
    chk("resume_tick1", 32'(TICK), 32'd1);
    chk("resume_led5", 32'(LEDR), 32'd5);
    cyc();
    chk("resume_led5b", 32'(LEDR), 32'd5);
    cyc();
    chk("resume_led6", 32'(LEDR), 32'd6);

    // Bounce mode over 8 ticks.
    do_reset(2'b10, 2'b00);
    for (int k = 1; k <= 64; k++) begin
      cyc();
      chk("bnc_tick", 32'(TICK), 32'((k % 8) == 0));
      chk("bnc_led", 32'(LEDR), 32'(bounce_exp(step_idx(k))));
    end

    // Reset mid-bounce, coinciding with a tick; count restarts from 0.
    do_reset(2'b00, 2'b00);
    for (int k = 1; k <= 10; k++) begin
      cyc();
      chk("rst2_tick", 32'(TICK), 32'((k % 8) == 0));
      chk("rst2_led", 32'(LEDR), 32'(step_idx(k)));
    end

    // Blink, speed 0 -> 3 with prescaler at 4.
    do_reset(2'b01, 2'b00);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk("blk_led", 32'(LEDR), (step_idx(k) % 2) ? 32'hF : 32'h0);
    end
    SPEED = 2'b11;
    for (int k = 13; k <= 24; k++) begin
      cyc();
      chk("blk_fast_tick", 32'(TICK), 32'd1);
      chk("blk_fast_led", 32'(LEDR),
          (k < 15) ? 32'hF : (((k - 15) % 2) == 0 ? 32'h0 : 32'hF));
    end

    // Blink, speed 0 -> 1 with prescaler at 5 (beyond new P-1 = 3).
    do_reset(2'b01, 2'b00);
    for (int k = 1; k <= 5; k++) cyc();
    SPEED = 2'b01;
    cyc();
    chk("spd1_tick_now", 32'(TICK), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("spd1_tick0", 32'(TICK), 32'd0);
    end
    cyc();
    chk("spd1_tick_p4", 32'(TICK), 32'd1);

    // Breathe over 16 ticks: duty triangle and PWM duty cycle.
    do_reset(2'b11, 2'b00);
    for (int k = 1; k <= 130; k++) begin
      int j;
      int duty;
      cyc();
      j = k - 1;
      duty = (j < 1) ? 0 : tri_duty((j - 1) / 8);
      chk("brt_tick", 32'(TICK), 32'((k % 8) == 0));
      chk("brt_led", 32'(LEDR), ((j % 8) < duty) ? 32'hF : 32'h0);
    end

    // Mode change 00 -> 10 on the edge that would have issued a tick.
    do_reset(2'b00, 2'b00);
    for (int k = 1; k <= 7; k++) cyc();
    MODE = 2'b10;
    cyc();
    chk("mc_no_tick", 32'(TICK), 32'd0);
    chk("mc_led_old", 32'(LEDR), 32'h0);
    cyc();
    chk("mc_led_pos0", 32'(LEDR), 32'b0001);
    for (int k = 10; k <= 15; k++) begin
      cyc();
      chk("mc_wait_tick", 32'(TICK), 32'd0);
      chk("mc_wait_led", 32'(LEDR), 32'b0001);
    end
    cyc();
    chk("mc_first_tick", 32'(TICK), 32'd1);
    cyc();
    chk("mc_led_hold", 32'(LEDR), 32'b0001);
    cyc();
    chk("mc_led_pos1", 32'(LEDR), 32'b0010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
